// File: rtl/sw_input_buffer_pkg.sv
// Shared packet-format definitions for the mesh switch input stage.
// Packet layout, MSB to LSB: {row_addr, col_addr, data}.
package sw_input_buffer_pkg;

  localparam int DEF_ADDR_COL_W = 4;
  localparam int DEF_ADDR_ROW_W = 4;
  localparam int DEF_DATA_W     = 8;
  localparam int DEF_FIFO_DEPTH_W = 2;

  function automatic int packet_width(input int row_w, input int col_w, input int data_w);
    return row_w + col_w + data_w;
  endfunction

endpackage

// File: rtl/sw_fifo_mem.sv
// Packet storage: synchronous write, asynchronous read, cleared on reset so
// the read port never presents X after reset.
module sw_fifo_mem #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [WIDTH-1:0]  wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [WIDTH-1:0]  rdata_o
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (we_i) begin
      r_mem[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = r_mem[raddr_i];

endmodule

// File: rtl/sw_input_buffer.sv
// Per-input-port packet FIFO feeding the XY router and crossbar. Head packet
// fields are a combinational view of the oldest stored entry.
module sw_input_buffer
  import sw_input_buffer_pkg::*;
#(
  parameter int PACKET_ADDR_COL_W = DEF_ADDR_COL_W,
  parameter int PACKET_ADDR_ROW_W = DEF_ADDR_ROW_W,
  parameter int DATA_W            = DEF_DATA_W,
  parameter int FIFO_DEPTH_W      = DEF_FIFO_DEPTH_W,
  localparam int PACKET_W = packet_width(PACKET_ADDR_ROW_W, PACKET_ADDR_COL_W, DATA_W)
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [PACKET_W-1:0]          packet_i,
  input  logic                         valid_i,
  output logic                         ready_o,
  output logic [PACKET_ADDR_COL_W-1:0] col_addr_o,
  output logic [PACKET_ADDR_ROW_W-1:0] row_addr_o,
  output logic [DATA_W-1:0]            data_o,
  output logic                         valid_o,
  input  logic                         pop_i,
  output logic [FIFO_DEPTH_W:0]        count_o
);

  // Handshakes: a push completes on an edge where valid_i && ready_o, a pop on
  // an edge where pop_i && valid_o. ready_o/valid_o come from pointer registers
  // only, so no input reaches a handshake output combinationally.
  logic [FIFO_DEPTH_W:0] r_wr_ptr;
  logic [FIFO_DEPTH_W:0] r_rd_ptr;
  logic                  w_empty;
  logic                  w_full;
  logic                  w_push;
  logic                  w_pop;
  logic [PACKET_W-1:0]   w_head;

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  // Same slot index but opposite wrap bits means the writer is a lap ahead.
  assign w_full  = (r_wr_ptr[FIFO_DEPTH_W-1:0] == r_rd_ptr[FIFO_DEPTH_W-1:0]) &&
                   (r_wr_ptr[FIFO_DEPTH_W] != r_rd_ptr[FIFO_DEPTH_W]);
  assign w_push  = valid_i && !w_full;
  assign w_pop   = pop_i && !w_empty;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  sw_fifo_mem #(
    .WIDTH  (PACKET_W),
    .ADDR_W (FIFO_DEPTH_W)
  ) u_mem (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .we_i    (w_push),
    .waddr_i (r_wr_ptr[FIFO_DEPTH_W-1:0]),
    .wdata_i (packet_i),
    .raddr_i (r_rd_ptr[FIFO_DEPTH_W-1:0]),
    .rdata_o (w_head)
  );

  assign ready_o    = !w_full;
  assign valid_o    = !w_empty;
  assign count_o    = r_wr_ptr - r_rd_ptr;
  assign data_o     = w_head[DATA_W-1:0];
  assign col_addr_o = w_head[DATA_W +: PACKET_ADDR_COL_W];
  assign row_addr_o = w_head[DATA_W + PACKET_ADDR_COL_W +: PACKET_ADDR_ROW_W];

endmodule

// File: tb/tb_sw_input_buffer.sv
// Bench for sw_input_buffer: directed scenarios plus random traffic, checked
// against a queue-based model of an in-order buffer of capacity DEPTH.
module tb_sw_input_buffer;

  localparam int COL_W    = 4;
  localparam int ROW_W    = 4;
  localparam int DATA_W   = 8;
  localparam int DEPTH_W  = 2;
  localparam int DEPTH    = 4;
  localparam int PACKET_W = ROW_W + COL_W + DATA_W;

  logic                clk_i;
  logic                rst_i;
  logic [PACKET_W-1:0] packet_i;
  logic                valid_i;
  logic                ready_o;
  logic [COL_W-1:0]    col_addr_o;
  logic [ROW_W-1:0]    row_addr_o;
  logic [DATA_W-1:0]   data_o;
  logic                valid_o;
  logic                pop_i;
  logic [DEPTH_W:0]    count_o;

  logic [PACKET_W-1:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  sw_input_buffer #(
    .PACKET_ADDR_COL_W (COL_W),
    .PACKET_ADDR_ROW_W (ROW_W),
    .DATA_W            (DATA_W),
    .FIFO_DEPTH_W      (DEPTH_W)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .packet_i   (packet_i),
    .valid_i    (valid_i),
    .ready_o    (ready_o),
    .col_addr_o (col_addr_o),
    .row_addr_o (row_addr_o),
    .data_o     (data_o),
    .valid_o    (valid_o),
    .pop_i      (pop_i),
    .count_o    (count_o)
  );

  // clock / reset
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an ordered list of held packets, capacity DEPTH.
  // Acceptance and release are decided from the occupancy before the edge.
  always @(posedge clk_i) begin
    if (rst_i) begin
      exp_q.delete();
    end else begin
      automatic int occ = exp_q.size();
      automatic bit do_pop  = pop_i && (occ > 0);
      automatic bit do_push = valid_i && (occ < DEPTH);
      if (do_pop)  void'(exp_q.pop_front());
      if (do_push) exp_q.push_back(packet_i);
    end
  end

  // Monitor: compare visible state and head packet every cycle mid-period.
  always @(negedge clk_i) begin
    automatic int occ = exp_q.size();
    check("valid_o", {31'd0, valid_o}, {31'd0, occ > 0});
    check("ready_o", {31'd0, ready_o}, {31'd0, occ < DEPTH});
    check("count_o", {29'd0, count_o}, occ);
    if (occ > 0)
      check("head_packet", {16'd0, row_addr_o, col_addr_o, data_o}, {16'd0, exp_q[0]});
  end

  // driver tasks: inputs change 1 time unit after the edge
  task automatic drive(input logic v, input logic [PACKET_W-1:0] p, input logic pp);
    @(posedge clk_i);
    #1;
    valid_i  = v;
    packet_i = p;
    pop_i    = pp;
  endtask

  function automatic logic [PACKET_W-1:0] rand_pkt();
    return PACKET_W'($urandom_range(0, 16'hFFFF));
  endfunction

  initial begin
    rst_i    = 1'b1;
    valid_i  = 1'b0;
    pop_i    = 1'b0;
    packet_i = '0;
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    #1;
    check("rst_valid", {31'd0, valid_o}, 32'd0);
    check("rst_ready", {31'd0, ready_o}, 32'd1);
    check("rst_count", {29'd0, count_o}, 32'd0);
    check("rst_head", {16'd0, row_addr_o, col_addr_o, data_o}, 32'd0);

    // pop while idle leaves the buffer empty
    drive(1'b0, '0, 1'b1);
    repeat (3) drive(1'b0, '0, 1'b1);
    drive(1'b0, '0, 1'b0);

    // single packet {row 2, col 1, data A5}
    drive(1'b1, 16'h21A5, 1'b0);
    drive(1'b0, '0, 1'b0);
    check("single_row", {28'd0, row_addr_o}, 32'd2);
    check("single_col", {28'd0, col_addr_o}, 32'd1);
    check("single_data", {24'd0, data_o}, 32'hA5);
    check("single_valid", {31'd0, valid_o}, 32'd1);
    drive(1'b0, '0, 1'b1);
    drive(1'b0, '0, 1'b0);
    check("single_popped", {31'd0, valid_o}, 32'd0);

    // fill to DEPTH, hold a fifth, then free one slot
    for (int i = 0; i < DEPTH; i++) drive(1'b1, rand_pkt(), 1'b0);
    drive(1'b1, 16'hBEEF, 1'b0);
    repeat (3) drive(1'b1, 16'hBEEF, 1'b0);
    check("full_count", {29'd0, count_o}, 32'd4);
    check("full_ready", {31'd0, ready_o}, 32'd0);
    drive(1'b1, 16'hBEEF, 1'b1);
    drive(1'b1, 16'hBEEF, 1'b0);
    check("after_pop_ready", {31'd0, ready_o}, 32'd1);
    drive(1'b0, '0, 1'b0);
    check("fifth_stored", {29'd0, count_o}, 32'd4);
    for (int i = 0; i < DEPTH; i++) drive(1'b0, '0, 1'b1);
    drive(1'b0, '0, 1'b0);
    check("drained", {29'd0, count_o}, 32'd0);

    // streaming at occupancy 2
    drive(1'b1, rand_pkt(), 1'b0);
    drive(1'b1, rand_pkt(), 1'b0);
    for (int i = 0; i < 20; i++) drive(1'b1, rand_pkt(), 1'b1);
    drive(1'b0, '0, 1'b0);
    check("stream_count", {29'd0, count_o}, 32'd2);

    // reset mid-operation with three stored
    drive(1'b1, rand_pkt(), 1'b0);
    drive(1'b0, '0, 1'b0);
    check("pre_reset_count", {29'd0, count_o}, 32'd3);
    #2;
    rst_i = 1'b1;
    #1;
    exp_q.delete();
    check("async_rst_valid", {31'd0, valid_o}, 32'd0);
    check("async_rst_count", {29'd0, count_o}, 32'd0);
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    drive(1'b1, 16'h3C5A, 1'b0);
    drive(1'b0, '0, 1'b0);
    check("post_reset_head", {16'd0, row_addr_o, col_addr_o, data_o}, 32'h3C5A);
    drive(1'b0, '0, 1'b1);
    drive(1'b0, '0, 1'b0);

    // push together with pop on empty
    drive(1'b1, 16'h7E11, 1'b1);
    drive(1'b0, '0, 1'b0);
    check("empty_push_pop_count", {29'd0, count_o}, 32'd1);
    drive(1'b0, '0, 1'b1);

    // random traffic
    for (int i = 0; i < 400; i++)
      drive(1'($urandom_range(0, 1)), rand_pkt(), 1'($urandom_range(0, 1)));
    while (exp_q.size() > 0) drive(1'b0, '0, 1'b1);
    drive(1'b0, '0, 1'b0);
    @(posedge clk_i);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sw_input_buffer.md
# sw_input_buffer

Per-input-port packet FIFO of the mesh switch, sitting directly upstream of the XY routing stage. Accepts packets from the neighbouring switch or the local resource over a valid/ready handshake. Stores them in a power-of-two circular buffer. Presents the head packet's column/row address fields to the router and its payload to the crossbar; the packet is released when the switch allocator pops it.

## Interface
Parameters:
- PACKET_ADDR_COL_W, 4, column address field width; must match the router.
- PACKET_ADDR_ROW_W, 4, row address field width; must match the router.
- DATA_W, 8, payload width.
- FIFO_DEPTH_W, 2, log2 of buffer depth (depth = 2**FIFO_DEPTH_W, minimum 1 → depth 2).
- Derived PACKET_W = PACKET_ADDR_ROW_W + PACKET_ADDR_COL_W + DATA_W; packet layout, MSB→LSB: {row_addr, col_addr, data}.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- packet_i  in  PACKET_W  incoming packet.
- valid_i  in  1  upstream has a packet on packet_i.
- ready_o  out  1  buffer can accept; equals !full.
- col_addr_o  out  PACKET_ADDR_COL_W  head packet column address (to router col_addr).
- row_addr_o  out  PACKET_ADDR_ROW_W  head packet row address (to router row_addr).
- data_o  out  DATA_W  head packet payload.
- valid_o  out  1  head packet present; equals !empty.
- pop_i  in  1  allocator consumes the head packet this cycle.
- count_o  out  FIFO_DEPTH_W+1  current occupancy, 0..depth.

## Operation
- Storage: memory array of depth entries × PACKET_W, write pointer, read pointer, each FIFO_DEPTH_W+1 bits (extra wrap bit).
- empty = (wr_ptr == rd_ptr); full = index bits equal and wrap bits differ.
- Push: valid_i && ready_o → write packet_i at wr_ptr index, wr_ptr += 1 (modulo 2**(FIFO_DEPTH_W+1)).
- Pop: pop_i && valid_o → rd_ptr += 1. pop_i while empty is ignored; no pointer movement.
- Simultaneous push and pop, non-empty and non-full: both occur, count unchanged.
- Full with pop_i: pop occurs; ready_o is low that cycle, so no push (no full-bypass); ready_o rises the next cycle.
- Empty with valid_i: push occurs; no cut-through. valid_o rises the next cycle.
- Head outputs are a combinational read of mem[rd_ptr index], split per the packet layout. They are don't-care while valid_o = 0 but must hold a stable, non-X value after reset: drive from memory cleared on reset.
- count_o = wr_ptr − rd_ptr, computed FIFO_DEPTH_W+1 bits wide, wrapping naturally.
- Pointers wrap silently; no overflow or underflow is possible through the handshake.

## Timing
- Reset, asynchronous and immediate: wr_ptr = rd_ptr = 0, memory cleared to 0. Outputs: valid_o = 0, ready_o = 1, count_o = 0, col_addr_o = row_addr_o = data_o = 0.
- Reset asserted mid-operation discards all stored packets. No handshake completes in a cycle whose edge sees rst_i high.
- Latency: a packet accepted at edge N is visible on the head outputs, with valid_o = 1, after edge N, if the FIFO was empty.
- Throughput: one push and one pop per cycle sustained.
- ready_o and valid_o depend only on registered state, never combinationally on valid_i or pop_i. No combinational path from input to output handshake.
- The router consumes the head address combinationally in the same cycle. The allocator asserts pop_i in the cycle it grants.

## Structure
- Shared header switch_params.v holds the packet field macros: row/column address widths, field offsets within the packet, and PACKET_W. It also holds the existing switch configuration defines.
- Single module; no sub-module required. The memory may be factored into a sub-module sw_fifo_mem, with a synchronous write port and an asynchronous read port, if reused by the output stage.
- Router instance stays outside; the switch top wires col_addr_o and row_addr_o to xy_router.

## Test plan
- Reset then idle: valid_o = 0, ready_o = 1, count_o = 0, head outputs = 0; pop_i = 1 for 3 cycles leaves count_o = 0.
- Single packet: DATA_W = 8, push {row 2, col 1, data 0xA5} → next cycle valid_o = 1, row_addr_o = 2, col_addr_o = 1, data_o = 0xA5. Pop → valid_o = 0 the following cycle.
- Fill: depth 4, push 4 packets → count_o = 4, ready_o = 0. Fifth valid_i is held and not stored. Pop once → ready_o = 1 next cycle; fifth is accepted after that. Pop order matches push order.
- Streaming: push and pop every cycle for 20 cycles at count 2 → count_o stays 2. Pointers wrap past depth; packets arrive in order with no loss or duplication.
- Reset mid-operation: 3 packets stored, assert rst_i between edges → valid_o = 0 and count_o = 0 immediately. After release, a new push gives the new packet at the head.
- Pop on empty together with push: empty, valid_i = 1 and pop_i = 1 → packet stored, count_o = 1 next cycle.
